// File: rtl/mem_ctrl.sv
// Single-ported word memory behind a valid/ready core port with programmable wait states.
// Misaligned and out-of-range accesses respond with err instead of aliasing into the array.
module mem_ctrl #(
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned LATENCY   = 1,
    parameter logic [31:0] ADDR_BASE = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        wvalid,
    output logic        wready,
    input  logic        rready,
    output logic        rvalid,
    output logic [31:0] mem_rdata,
    output logic        err
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        op_wr_q, op_wr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] index;
    logic          addr_err;
    logic          do_access;

    // ADDR_BASE is aligned to 4*DEPTH, so the range check reduces to matching the upper bits.
    assign index     = addr_q[AW+1:2];
    assign addr_err  = (addr_q[1:0] != 2'b00) || (addr_q[31:AW+2] != ADDR_BASE[31:AW+2]);
    assign do_access = (state_q == StBusy) && (cnt_q == 4'd0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_wr_d = op_wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            StIdle: begin
                if (wvalid) begin
                    op_wr_d = 1'b1;
                    addr_d  = mem_addr;
                    wdata_d = mem_wdata;
                    cnt_d   = 4'(LATENCY);
                    state_d = StBusy;
                end else if (rready) begin
                    op_wr_d = 1'b0;
                    addr_d  = mem_addr;
                    cnt_d   = 4'(LATENCY);
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = StResp;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            op_wr_q   <= 1'b0;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            wready    <= 1'b0;
            rvalid    <= 1'b0;
            err       <= 1'b0;
            mem_rdata <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_wr_q <= op_wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            // Response flags are high only for the single RESP cycle.
            wready  <= do_access && op_wr_q;
            rvalid  <= do_access && !op_wr_q;
            err     <= do_access && addr_err;
            if (do_access && !op_wr_q) begin
                mem_rdata <= addr_err ? 32'h0 : mem[index];
            end
        end
    end

    // Array is deliberately left without reset.
    always_ff @(posedge clk) begin
        if (do_access && op_wr_q && !addr_err) begin
            mem[index] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: four instances cover LATENCY 1/0/15/5 and a non-zero ADDR_BASE.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] addr_s  [4];
    logic [31:0] wdata_s [4];
    logic [31:0] rdata_s [4];
    logic        wvalid_s [4];
    logic        rready_s [4];
    logic        wready_s [4];
    logic        rvalid_s [4];
    logic        err_s    [4];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_ctrl #(.DEPTH(1024), .LATENCY(1), .ADDR_BASE(32'h0)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .mem_addr(addr_s[0]), .mem_wdata(wdata_s[0]),
        .wvalid(wvalid_s[0]), .wready(wready_s[0]), .rready(rready_s[0]),
        .rvalid(rvalid_s[0]), .mem_rdata(rdata_s[0]), .err(err_s[0])
    );
    mem_ctrl #(.DEPTH(1024), .LATENCY(0), .ADDR_BASE(32'h2000)) u_lat0 (
        .clk(clk), .rst_n(rst_n), .mem_addr(addr_s[1]), .mem_wdata(wdata_s[1]),
        .wvalid(wvalid_s[1]), .wready(wready_s[1]), .rready(rready_s[1]),
        .rvalid(rvalid_s[1]), .mem_rdata(rdata_s[1]), .err(err_s[1])
    );
    mem_ctrl #(.DEPTH(1024), .LATENCY(15), .ADDR_BASE(32'h0)) u_lat15 (
        .clk(clk), .rst_n(rst_n), .mem_addr(addr_s[2]), .mem_wdata(wdata_s[2]),
        .wvalid(wvalid_s[2]), .wready(wready_s[2]), .rready(rready_s[2]),
        .rvalid(rvalid_s[2]), .mem_rdata(rdata_s[2]), .err(err_s[2])
    );
    mem_ctrl #(.DEPTH(1024), .LATENCY(5), .ADDR_BASE(32'h0)) u_lat5 (
        .clk(clk), .rst_n(rst_n), .mem_addr(addr_s[3]), .mem_wdata(wdata_s[3]),
        .wvalid(wvalid_s[3]), .wready(wready_s[3]), .rready(rready_s[3]),
        .rvalid(rvalid_s[3]), .mem_rdata(rdata_s[3]), .err(err_s[3])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input int k, input string tag);
        check_eq({tag, " flags"}, 32'({wready_s[k], rvalid_s[k], err_s[k]}), 32'h0);
        check_eq({tag, " rdata"}, rdata_s[k], 32'h0);
    endtask

    // Request goes high just after a rising edge; that cycle is cycle 0.
    task automatic start_req(input int k, input bit wr, input logic [31:0] a,
                             input logic [31:0] d);
        @(posedge clk);
        #1;
        addr_s[k]  = a;
        wdata_s[k] = d;
        if (wr) wvalid_s[k] = 1'b1;
        else    rready_s[k] = 1'b1;
    endtask

    // cyc is the cycle number of the response; -1 when no response arrives in budget.
    task automatic wait_resp(input int k, input int first, output int cyc, output logic was_wr,
                             output logic e, output logic [31:0] rd);
        cyc    = first;
        was_wr = 1'b0;
        e      = 1'b0;
        rd     = 32'h0;
        repeat (40) begin
            @(negedge clk);
            if (wready_s[k] || rvalid_s[k]) begin
                was_wr = wready_s[k];
                e      = err_s[k];
                rd     = rdata_s[k];
                return;
            end
            cyc++;
        end
        cyc = -1;
    endtask

    task automatic access(input int k, input bit wr, input logic [31:0] a, input logic [31:0] d,
                          input int exp_cyc, input logic exp_err, input logic [31:0] exp_data,
                          input string tag);
        int          cyc;
        logic        was_wr, e;
        logic [31:0] rd;
        start_req(k, wr, a, d);
        wait_resp(k, 0, cyc, was_wr, e, rd);
        wvalid_s[k] = 1'b0;
        rready_s[k] = 1'b0;
        check_eq({tag, " cycle"}, 32'(cyc), 32'(exp_cyc));
        check_eq({tag, " kind"}, 32'(was_wr), 32'(wr));
        check_eq({tag, " err"}, 32'(e), 32'(exp_err));
        if (!wr) check_eq({tag, " data"}, rd, exp_data);
    endtask

    // Read issued in cycle 0; in cycle 1 (BUSY) the address moves and rready drops.
    task automatic sweep(input int k, input logic [31:0] a, input logic [31:0] other,
                         input int exp_cyc, input logic [31:0] exp_data, input string tag);
        int          cyc;
        logic        was_wr, e;
        logic [31:0] rd;
        start_req(k, 1'b0, a, 32'h0);
        @(posedge clk);
        #1;
        addr_s[k]   = other;
        rready_s[k] = 1'b0;
        wait_resp(k, 1, cyc, was_wr, e, rd);
        check_eq({tag, " cycle"}, 32'(cyc), 32'(exp_cyc));
        check_eq({tag, " data"}, rd, exp_data);
        check_eq({tag, " err"}, 32'(e), 32'h0);
    endtask

    initial begin
        int          cyc;
        logic        was_wr, e;
        logic [31:0] rd;

        for (int i = 0; i < 4; i++) begin
            addr_s[i]   = 32'h0;
            wdata_s[i]  = 32'h0;
            wvalid_s[i] = 1'b0;
            rready_s[i] = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        check_idle(0, "por lat1");
        check_idle(3, "por lat5");
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        access(0, 1'b1, 32'h10, 32'hDEADBEEF, 3, 1'b0, 32'h0, "wr 0x10");
        access(0, 1'b0, 32'h10, 32'h0, 3, 1'b0, 32'hDEADBEEF, "rd 0x10");

        // Reset lands mid-cycle while a read response is on the outputs.
        start_req(0, 1'b0, 32'h10, 32'h0);
        wait_resp(0, 0, cyc, was_wr, e, rd);
        check_eq("pre-reset rdata", rd, 32'hDEADBEEF);
        #2 rst_n = 1'b0;
        rready_s[0] = 1'b0;
        #1;
        check_idle(0, "async reset");
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            check_idle(0, "idle after reset");
        end

        access(0, 1'b1, 32'h0,    32'h11112222, 3, 1'b0, 32'h0, "wr 0x0");
        access(0, 1'b1, 32'hFFC,  32'hCAFEF00D, 3, 1'b0, 32'h0, "wr 0xFFC");
        access(0, 1'b0, 32'hFFC,  32'h0,        3, 1'b0, 32'hCAFEF00D, "rd 0xFFC");
        access(0, 1'b1, 32'h1000, 32'h55555555, 3, 1'b1, 32'h0, "wr 0x1000");
        access(0, 1'b0, 32'h0,    32'h0,        3, 1'b0, 32'h11112222, "rd 0x0 after oor");
        access(0, 1'b0, 32'h2,    32'h0,        3, 1'b1, 32'h0, "rd 0x2");

        // Both requests in cycle 0: write answers in cycle 3, read re-accepted in cycle 4.
        @(posedge clk);
        #1;
        addr_s[0]   = 32'h20;
        wdata_s[0]  = 32'h12345678;
        wvalid_s[0] = 1'b1;
        rready_s[0] = 1'b1;
        wait_resp(0, 0, cyc, was_wr, e, rd);
        wvalid_s[0] = 1'b0;
        check_eq("simul wr cycle", 32'(cyc), 32'd3);
        check_eq("simul wr kind", 32'(was_wr), 32'd1);
        wait_resp(0, 4, cyc, was_wr, e, rd);
        rready_s[0] = 1'b0;
        check_eq("simul rd cycle", 32'(cyc), 32'd7);
        check_eq("simul rd kind", 32'(was_wr), 32'd0);
        check_eq("simul rd data", rd, 32'h12345678);

        access(1, 1'b1, 32'h2100, 32'hAAAA0001, 2, 1'b0, 32'h0, "lat0 wr A");
        access(1, 1'b1, 32'h2104, 32'hBBBB0002, 2, 1'b0, 32'h0, "lat0 wr B");
        sweep(1, 32'h2100, 32'h2104, 2, 32'hAAAA0001, "lat0 sweep");
        access(1, 1'b0, 32'h2104, 32'h0, 2, 1'b0, 32'hBBBB0002, "lat0 rd B");
        access(1, 1'b0, 32'h1FFC, 32'h0, 2, 1'b1, 32'h0, "lat0 below base");

        access(2, 1'b1, 32'h100, 32'hAAAA0015, 17, 1'b0, 32'h0, "lat15 wr A");
        access(2, 1'b1, 32'h104, 32'hBBBB0015, 17, 1'b0, 32'h0, "lat15 wr B");
        sweep(2, 32'h100, 32'h104, 17, 32'hAAAA0015, "lat15 sweep");

        access(3, 1'b1, 32'h40, 32'hA5A5A5A5, 7, 1'b0, 32'h0, "lat5 wr init");
        start_req(3, 1'b1, 32'h40, 32'h0BADF00D);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        wvalid_s[3] = 1'b0;
        #2 rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            check_eq("abandoned wready", 32'(wready_s[3]), 32'h0);
        end
        access(3, 1'b0, 32'h40, 32'h0, 7, 1'b0, 32'hA5A5A5A5, "lat5 rd after abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
